// File: rtl/pipelined_adder.sv
// pipelined_adder
//   Wide adder with carry-in, split into STAGES equal chunks of CW = WIDTH/STAGES
//   bits. Each register stage adds one chunk, so the critical path is a single
//   CW-bit adder. The carry ripples from one stage to the next. A single
//   advance signal stalls the whole pipeline when the downstream side is not
//   ready.
//
// Parameters
//   WIDTH   operand/sum width, a multiple of STAGES
//   STAGES  pipeline depth = number of chunks (1..WIDTH)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   a/b/cin valid
//   in_ready   block accepts this cycle (combinational from out_valid/out_ready)
//   a, b, cin  operands and carry-in
//   out_valid  sum/cout/ovf valid
//   out_ready  downstream accepts this cycle
//   sum        (a + b + cin) mod 2^WIDTH
//   cout       unsigned carry out of bit WIDTH-1
//   ovf        signed overflow (carry into MSB xor carry out of MSB)
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = WIDTH / STAGES;

  function automatic logic [CW:0] chunk_add(input logic [CW-1:0] x,
                                            input logic [CW-1:0] y,
                                            input logic          ci);
    chunk_add = {1'b0, x} + {1'b0, y} + {{CW{1'b0}}, ci};
  endfunction

  // The carry into the MSB is recovered from that bit's full-adder inputs and
  // its sum bit, so no extra carry tap is needed inside the chunk adder.
  function automatic logic msb_overflow(input logic am, input logic bm,
                                        input logic sm, input logic co);
    msb_overflow = (am ^ bm ^ sm) ^ co;
  endfunction

  // Operand registers hold the not-yet-consumed chunks shifted down so the
  // next chunk always sits at bit 0; the vacated upper bits are constant zero,
  // which keeps the storage triangular after constant propagation.
  logic [WIDTH-1:0]  a_p   [STAGES];
  logic [WIDTH-1:0]  b_p   [STAGES];
  logic [WIDTH-1:0]  sum_p [STAGES];
  logic              cy_p  [STAGES];
  logic [STAGES-1:0] vld_p;
  logic              ovf_p;

  logic              adv;

  logic [WIDTH-1:0]  a_cur [STAGES];
  logic [WIDTH-1:0]  b_cur [STAGES];
  logic [WIDTH-1:0]  s_cur [STAGES];
  logic              c_cur [STAGES];
  logic [CW:0]       csum  [STAGES];
  logic [WIDTH-1:0]  s_nxt [STAGES];
  logic              ovf_nxt;

  assign adv       = !vld_p[STAGES-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_p[STAGES-1];
  assign sum       = sum_p[STAGES-1];
  assign cout      = cy_p[STAGES-1];
  assign ovf       = ovf_p;

  always_comb begin
    a_cur[0] = a;
    b_cur[0] = b;
    s_cur[0] = '0;
    c_cur[0] = cin;
    for (int k = 1; k < STAGES; k++) begin
      a_cur[k] = a_p[k-1];
      b_cur[k] = b_p[k-1];
      s_cur[k] = sum_p[k-1];
      c_cur[k] = cy_p[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      csum[k]                 = chunk_add(a_cur[k][CW-1:0], b_cur[k][CW-1:0], c_cur[k]);
      s_nxt[k]                = s_cur[k];
      s_nxt[k][k*CW +: CW]    = csum[k][CW-1:0];
    end
    ovf_nxt = msb_overflow(a_cur[STAGES-1][CW-1], b_cur[STAGES-1][CW-1],
                           csum[STAGES-1][CW-1], csum[STAGES-1][CW]);
  end

  // ---- stage registers: chunk k result, lower sums, remaining operands ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
      ovf_p <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_p[k]   <= '0;
        b_p[k]   <= '0;
        sum_p[k] <= '0;
        cy_p[k]  <= 1'b0;
      end
    end else if (adv) begin
      vld_p[0] <= in_valid && in_ready;
      for (int k = 1; k < STAGES; k++) begin
        vld_p[k] <= vld_p[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        a_p[k]   <= a_cur[k] >> CW;
        b_p[k]   <= b_cur[k] >> CW;
        sum_p[k] <= s_nxt[k];
        cy_p[k]  <= csum[k][CW];
      end
      ovf_p <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder
//   Directed bench for pipelined_adder: a 32-bit/4-stage instance (main), a
//   32-bit/1-stage instance sharing the main inputs, and an 8-bit/8-stage
//   instance with its own inputs.
module tb_pipelined_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, out_ready, cin;
  logic [31:0] a, b;
  logic        in_ready, out_valid, cout, ovf;
  logic [31:0] sum;

  logic        s1_in_ready, s1_out_valid, s1_cout, s1_ovf;
  logic [31:0] s1_sum;

  logic        w8_in_valid, w8_cin, w8_in_ready, w8_out_valid, w8_cout, w8_ovf;
  logic [7:0]  w8_a, w8_b, w8_sum;

  pipelined_adder #(.WIDTH(32), .STAGES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipelined_adder #(.WIDTH(32), .STAGES(1)) u_dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s1_in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(s1_out_valid), .out_ready(out_ready),
    .sum(s1_sum), .cout(s1_cout), .ovf(s1_ovf)
  );

  pipelined_adder #(.WIDTH(8), .STAGES(8)) u_dut_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(w8_in_valid), .in_ready(w8_in_ready),
    .a(w8_a), .b(w8_b), .cin(w8_cin), .out_valid(w8_out_valid), .out_ready(1'b1),
    .sum(w8_sum), .cout(w8_cout), .ovf(w8_ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain wide add; overflow from the operand/result sign rule.
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic ci);
    logic [32:0] t;
    logic        o;
    t = {1'b0, x} + {1'b0, y} + {32'd0, ci};
    o = (x[31] == y[31]) && (t[31] != x[31]);
    return {o, t};
  endfunction

  // Transfer monitor, sampled on the falling edge where inputs are stable.
  int          cyc = 0;
  logic        acc_seen = 1'b0;
  logic [33:0] rx_q [$];
  int          rx_cyc [$];
  logic [33:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    acc_seen <= rst_n && in_valid && in_ready;
    if (rst_n && out_valid && out_ready) begin
      rx_q.push_back({ovf, cout, sum});
      rx_cyc.push_back(cyc);
    end
    if (rst_n && in_valid && in_ready) exp_q.push_back(model(a, b, cin));
  end

  // One op through the main and 1-stage instances; expects an idle pipeline.
  task automatic basic(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                       input logic tc, input logic [31:0] es, input logic ec, input logic eo);
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = ta; b = tb_; cin = tc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    check({tag, "_s1_valid"}, 64'(s1_out_valid), 64'(1'b1));
    check({tag, "_s1_data"}, 64'({s1_ovf, s1_cout, s1_sum}), 64'({eo, ec, es}));
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(3));
    check({tag, "_data"}, 64'({ovf, cout, sum}), 64'({eo, ec, es}));
    @(posedge clk); #1;
    check({tag, "_once"}, 64'(out_valid), 64'(1'b0));
  endtask

  task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                     input logic tc, input logic [7:0] es, input logic ec, input logic eo);
    int lat;
    w8_in_valid = 1'b1;
    w8_a = ta; w8_b = tb_; w8_cin = tc;
    @(posedge clk); #1;
    w8_in_valid = 1'b0;
    lat = 0;
    while (!w8_out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(7));
    check({tag, "_data"}, 64'({w8_ovf, w8_cout, w8_sum}), 64'({eo, ec, es}));
  endtask

  // Stream n ops. pat 0: a=i, b=0x10*i; pat 1: carry-heavy operands.
  // mode 0: always ready; 1: 5-cycle stall once full; 2: out_ready toggles.
  task automatic stream(input string tag, input int n, input int pat, input int mode);
    int          j;
    logic [33:0] held;
    j = 0;
    held = '0;
    rx_q.delete(); rx_cyc.delete(); exp_q.delete();
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (acc_seen) j++;
      if (j >= n && rx_q.size() >= n) break;
      in_valid = (j < n);
      cin      = j[0];
      if (pat == 0) begin
        a = 32'(j);
        b = 32'(j) * 32'h10;
      end else begin
        a = 32'hFFFF_FFF0 + 32'(j);
        b = 32'(j) * 32'h0100_0000 + 32'h10;
      end
      case (mode)
        1:       out_ready = !(c >= 6 && c < 11);
        2:       out_ready = (c % 2 == 1);
        default: out_ready = 1'b1;
      endcase
      if (mode == 1 && c >= 6 && c < 11) begin
        a = $urandom;
        b = $urandom;
      end
      #1;
      if (mode == 1 && c >= 6 && c < 11) begin
        check({tag, "_stall_in_ready"}, 64'(in_ready), 64'(1'b0));
        if (c == 6) held = {ovf, cout, sum};
        else begin
          check({tag, "_stall_hold"}, 64'({ovf, cout, sum}), 64'(held));
          check({tag, "_stall_valid"}, 64'(out_valid), 64'(1'b1));
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check({tag, "_accepted"}, 64'(exp_q.size()), 64'(n));
    check({tag, "_count"}, 64'(rx_q.size()), 64'(n));
    for (int i = 0; i < n && i < rx_q.size() && i < exp_q.size(); i++)
      check({tag, "_order"}, 64'(rx_q[i]), 64'(exp_q[i]));
  endtask

  logic [31:0] stream_tbl [8] = '{32'h00, 32'h12, 32'h22, 32'h34,
                                  32'h44, 32'h56, 32'h66, 32'h78};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    w8_in_valid = 1'b0; w8_a = '0; w8_b = '0; w8_cin = 1'b0;

    @(posedge clk); #1;
    check("rst_out_valid", 64'(out_valid), 64'(1'b0));
    check("rst_outputs", 64'({ovf, cout, sum}), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1'b1));
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_in_ready", 64'(in_ready), 64'(1'b1));
    check("rel_out_valid", 64'(out_valid), 64'(1'b0));

    basic("basic",    32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0);
    basic("ripple1",  32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    basic("ripple2",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    basic("ovf_pos",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    basic("ovf_neg",  32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    basic("chunk_cy", 32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0, 1'b0);

    stream("stream", 8, 0, 0);
    for (int i = 0; i < 8 && i < rx_q.size(); i++)
      check("stream_tbl", 64'(rx_q[i]), 64'(stream_tbl[i]));
    for (int i = 1; i < 8 && i < rx_cyc.size(); i++)
      check("stream_consec", 64'(rx_cyc[i]), 64'(rx_cyc[i-1] + 1));

    stream("bp_stall", 12, 1, 1);
    stream("bp_toggle", 10, 1, 2);

    // Reset with op0 at the output and two more ops in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = 32'h1111_1111 * 32'(i + 1);
      b = 32'h1;
      cin = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_pre_valid", 64'(out_valid), 64'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    check("mid_async_valid", 64'(out_valid), 64'(1'b0));
    check("mid_async_data", 64'({ovf, cout, sum}), 64'(0));
    check("mid_in_ready", 64'(in_ready), 64'(1'b1));
    @(posedge clk); #3;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 0) check("mid_rel_in_ready", 64'(in_ready), 64'(1'b1));
      if (out_valid) seen = 1'b1;
    end
    check("mid_no_stale", 64'(seen), 64'(1'b0));
    basic("recover", 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0);

    op8("w8_wrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("w8_ovf",  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
